key_debounce: RTL and testbench

//  Board push-button/DIP input conditioner; the input-side counterpart of the LED output driver.

---
 rtl/key_debounce.sv | 198 +++++++++++++++++++
 tb/tb_key_debounce.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - multi-key synchroniser/debouncer with press, release and long-press strobes
//
// Conditions KEY_NUM raw key pins in the CLK_i domain. Each key passes
// through a 2-flop synchroniser and has its polarity normalised (1 = pressed).
// It is then debounced against a shared 1 ms tick.
//
// Optional feature macro: KEY_LONG_PRESS_EN (adds per-key hold counters and LONG_o)
//
// Ports:
//   CLK_i        in   1        global clock
//   RST_i        in   1        synchronous reset, active-high
//   KEY_i        in   KEY_NUM  raw asynchronous key pins
//   KEY_STATE_o  out  KEY_NUM  debounced level per key, 1 = pressed
//   PRESS_o      out  KEY_NUM  1-cycle strobe on debounced 0->1
//   RELEASE_o    out  KEY_NUM  1-cycle strobe on debounced 1->0
//   LONG_o       out  KEY_NUM  1-cycle strobe after a key is held LONG_MS (0 without the macro)

module key_debounce #(
    parameter int CLK_FREQ       = 300_000_000,
    parameter int KEY_NUM        = 8,
    parameter int DEBOUNCE_MS    = 20,
    parameter int LONG_MS        = 1000,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic               CLK_i,
    input  logic               RST_i,
    input  logic [KEY_NUM-1:0] KEY_i,
    output logic [KEY_NUM-1:0] KEY_STATE_o,
    output logic [KEY_NUM-1:0] PRESS_o,
    output logic [KEY_NUM-1:0] RELEASE_o,
    output logic [KEY_NUM-1:0] LONG_o
);

    localparam int DIV = CLK_FREQ / 1000;
    localparam int PW  = $clog2(DIV);
    localparam int DW  = $clog2(DEBOUNCE_MS + 1);

    // Synchroniser reset value is the released pin level, so reset never looks like a press.
    localparam logic [KEY_NUM-1:0] IDLE_LVL = (KEY_ACTIVE_LOW != 0) ? {KEY_NUM{1'b1}} : {KEY_NUM{1'b0}};

    if (CLK_FREQ % 1000 != 0 || CLK_FREQ < 2000 || DEBOUNCE_MS < 1 || LONG_MS <= DEBOUNCE_MS) begin : g_bad_cfg
        $error("key_debounce: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        REL_WAIT
    } state_t;

    logic [KEY_NUM-1:0] key_meta;
    logic [KEY_NUM-1:0] key_sync;
    logic [KEY_NUM-1:0] s_key;
    logic [PW-1:0]      pre_cnt;
    logic               tick;

    state_t             state     [KEY_NUM];
    state_t             state_nxt [KEY_NUM];
    logic [DW-1:0]      dcnt      [KEY_NUM];
    logic [DW-1:0]      dcnt_nxt  [KEY_NUM];
    logic [KEY_NUM-1:0] press_nxt;
    logic [KEY_NUM-1:0] release_nxt;
    logic [KEY_NUM-1:0] level_nxt;

    assign s_key = (KEY_ACTIVE_LOW != 0) ? ~key_sync : key_sync;
    assign tick  = (pre_cnt == PW'(DIV - 1));

    always_comb begin
        for (int k = 0; k < KEY_NUM; k++) begin
            state_nxt[k]   = state[k];
            dcnt_nxt[k]    = dcnt[k];
            press_nxt[k]   = 1'b0;
            release_nxt[k] = 1'b0;

            case (state[k])
                IDLE: begin
                    if (s_key[k]) begin
                        state_nxt[k] = PRESS_WAIT;
                        dcnt_nxt[k]  = '0;
                    end
                end
                PRESS_WAIT: begin
                    // Bounce is tested first so it beats a coincident tick.
                    if (!s_key[k]) begin
                        state_nxt[k] = IDLE;
                        dcnt_nxt[k]  = '0;
                    end else if (tick) begin
                        if (dcnt[k] == DW'(DEBOUNCE_MS - 1)) begin
                            state_nxt[k] = PRESSED;
                            dcnt_nxt[k]  = '0;
                            press_nxt[k] = 1'b1;
                        end else begin
                            dcnt_nxt[k] = dcnt[k] + DW'(1);
                        end
                    end
                end
                PRESSED: begin
                    if (!s_key[k]) begin
                        state_nxt[k] = REL_WAIT;
                        dcnt_nxt[k]  = '0;
                    end
                end
                REL_WAIT: begin
                    if (s_key[k]) begin
                        state_nxt[k] = PRESSED;
                        dcnt_nxt[k]  = '0;
                    end else if (tick) begin
                        if (dcnt[k] == DW'(DEBOUNCE_MS - 1)) begin
                            state_nxt[k]   = IDLE;
                            dcnt_nxt[k]    = '0;
                            release_nxt[k] = 1'b1;
                        end else begin
                            dcnt_nxt[k] = dcnt[k] + DW'(1);
                        end
                    end
                end
                default: begin
                    state_nxt[k] = IDLE;
                    dcnt_nxt[k]  = '0;
                end
            endcase

            level_nxt[k] = (state_nxt[k] == PRESSED) || (state_nxt[k] == REL_WAIT);
        end
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            key_meta    <= IDLE_LVL;
            key_sync    <= IDLE_LVL;
            pre_cnt     <= '0;
            KEY_STATE_o <= '0;
            PRESS_o     <= '0;
            RELEASE_o   <= '0;
            for (int k = 0; k < KEY_NUM; k++) begin
                state[k] <= IDLE;
                dcnt[k]  <= '0;
            end
        end else begin
            key_meta    <= KEY_i;
            key_sync    <= key_meta;
            pre_cnt     <= tick ? '0 : pre_cnt + PW'(1);
            KEY_STATE_o <= level_nxt;
            PRESS_o     <= press_nxt;
            RELEASE_o   <= release_nxt;
            for (int k = 0; k < KEY_NUM; k++) begin
                state[k] <= state_nxt[k];
                dcnt[k]  <= dcnt_nxt[k];
            end
        end
    end

`ifdef KEY_LONG_PRESS_EN
    // Hold time is measured from the accepted press, so the target excludes the debounce time.
    localparam int HOLD_T = LONG_MS - DEBOUNCE_MS;
    localparam int HW     = $clog2(HOLD_T + 1);

    logic [HW-1:0]      hold     [KEY_NUM];
    logic [HW-1:0]      hold_nxt [KEY_NUM];
    logic [KEY_NUM-1:0] long_nxt;
    logic [KEY_NUM-1:0] long_r;

    always_comb begin
        for (int k = 0; k < KEY_NUM; k++) begin
            hold_nxt[k] = hold[k];
            long_nxt[k] = 1'b0;
            if (press_nxt[k]) begin
                hold_nxt[k] = '0;
            end else if (tick && (state[k] == PRESSED || state[k] == REL_WAIT)
                         && hold[k] != HW'(HOLD_T)) begin
                // Saturates at HOLD_T, giving one strobe per press.
                hold_nxt[k] = hold[k] + HW'(1);
                long_nxt[k] = (hold[k] == HW'(HOLD_T - 1));
            end
        end
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            long_r <= '0;
            for (int k = 0; k < KEY_NUM; k++) begin
                hold[k] <= '0;
            end
        end else begin
            long_r <= long_nxt;
            for (int k = 0; k < KEY_NUM; k++) begin
                hold[k] <= hold_nxt[k];
            end
        end
    end

    assign LONG_o = long_r;
`else
    assign LONG_o = '0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed self-checking bench for key_debounce

module tb_key_debounce;

    logic       clk = 1'b0;
    logic       RST_i;
    logic [1:0] KEY_i;
    logic [1:0] KEY_STATE_o;
    logic [1:0] PRESS_o;
    logic [1:0] RELEASE_o;
    logic [1:0] LONG_o;

    key_debounce #(
        .CLK_FREQ      (10_000),
        .KEY_NUM       (2),
        .DEBOUNCE_MS   (3),
        .LONG_MS       (8),
        .KEY_ACTIVE_LOW(1)
    ) dut (
        .CLK_i      (clk),
        .RST_i      (RST_i),
        .KEY_i      (KEY_i),
        .KEY_STATE_o(KEY_STATE_o),
        .PRESS_o    (PRESS_o),
        .RELEASE_o  (RELEASE_o),
        .LONG_o     (LONG_o)
    );

    always #5 clk = ~clk;

`ifdef KEY_LONG_PRESS_EN
    localparam int LONG_EXP = 1;
`else
    localparam int LONG_EXP = 0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Edges since the last reset release; the prescaler is 0 whenever cyc % 10 == 0.
    int cyc = 0;
    always @(posedge clk) begin
        if (RST_i) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int press_cnt [2];
    int rel_cnt   [2];
    int long_cnt  [2];
    int press_at  [2];
    int rel_at    [2];
    int long_at   [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            press_cnt[k] = 0; rel_cnt[k] = 0; long_cnt[k] = 0;
            press_at[k] = -1; rel_at[k] = -1; long_at[k] = -1;
        end
    end

    // Counts high samples, so a two-cycle strobe shows up as a count of 2.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (PRESS_o[k])   begin press_cnt[k]++; press_at[k] = cyc; end
            if (RELEASE_o[k]) begin rel_cnt[k]++;   rel_at[k]   = cyc; end
            if (LONG_o[k])    begin long_cnt[k]++;  long_at[k]  = cyc; end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic align(input int ph);
        int guard = 0;
        while ((cyc % 10) != ph && guard < 20) begin
            @(negedge clk);
            guard++;
        end
    endtask

    // Pin changed after edge c: 2 sync edges, 1 edge into PRESS_WAIT/REL_WAIT,
    // then the strobe lands on the third tick edge (multiples of 10) at or after c+4.
    function automatic int exp_edge(input int c);
        return ((c + 13) / 10) * 10 + 20;
    endfunction

    int c;
    int p0, r0, l0;
    int long_lat;

    initial begin
        RST_i = 1'b1;
        KEY_i = 2'b11;

        // 1. reset and idle
        cycles(5);
        check("rst_outputs", int'({KEY_STATE_o, PRESS_o, RELEASE_o, LONG_o}), 0);
        RST_i = 1'b0;
        cycles(100);
        check("idle_strobes", press_cnt[0] + press_cnt[1] + rel_cnt[0] + rel_cnt[1]
                              + long_cnt[0] + long_cnt[1], 0);
        check("idle_state", int'(KEY_STATE_o), 0);

        // 2. clean press and release on key 0
        align(7);
        c = cyc;
        KEY_i[0] = 1'b0;
        cycles(40);
        check("t2_press_cnt", press_cnt[0], 1);
        check("t2_press_lat", press_at[0] - c, 33);
        check("t2_state", int'(KEY_STATE_o), 1);
        check("t2_key1_quiet", press_cnt[1], 0);
        align(8);
        c = cyc;
        KEY_i[0] = 1'b1;
        cycles(40);
        check("t2_rel_cnt", rel_cnt[0], 1);
        check("t2_rel_lat", rel_at[0] - c, 32);
        check("t2_rel_state", int'(KEY_STATE_o), 0);

        // 3. bouncing input never settles long enough
        p0 = press_cnt[0];
        r0 = rel_cnt[0];
        for (int i = 0; i < 28; i++) begin
            KEY_i[0] = ~KEY_i[0];
            cycles(7);
        end
        check("t3_no_press", press_cnt[0], p0);
        check("t3_no_rel", rel_cnt[0], r0);
        check("t3_state", int'(KEY_STATE_o), 0);
        c = cyc;
        KEY_i[0] = 1'b0;
        cycles(40);
        check("t3_final_press", press_cnt[0], p0 + 1);
        check("t3_final_edge", press_at[0], exp_edge(c));
        KEY_i[0] = 1'b1;
        cycles(40);
        check("t3_final_rel", rel_cnt[0], r0 + 1);

        // 4. both keys together
        p0 = press_cnt[0];
        align(9);
        c = cyc;
        KEY_i = 2'b00;
        cycles(40);
        check("t4_k0_cnt", press_cnt[0], p0 + 1);
        check("t4_k1_cnt", press_cnt[1], 1);
        check("t4_k0_edge", press_at[0] - c, 31);
        check("t4_k1_edge", press_at[1] - c, 31);
        check("t4_state", int'(KEY_STATE_o), 3);
        KEY_i = 2'b11;
        cycles(40);
        check("t4_k1_rel", rel_cnt[1], 1);
        check("t4_rel_state", int'(KEY_STATE_o), 0);

        // 5. reset mid-debounce with the key kept down
        p0 = press_cnt[0];
        KEY_i[0] = 1'b0;
        cycles(18);
        RST_i = 1'b1;
        cycles(3);
        check("t5_no_strobe", press_cnt[0], p0);
        check("t5_rst_outputs", int'({KEY_STATE_o, PRESS_o, RELEASE_o, LONG_o}), 0);
        RST_i = 1'b0;
        cycles(40);
        check("t5_press_cnt", press_cnt[0], p0 + 1);
        check("t5_press_edge", press_at[0], 30);
        KEY_i[0] = 1'b1;
        cycles(40);

        // 6. long hold
        p0 = press_cnt[0];
        l0 = long_cnt[0];
        align(7);
        c = cyc;
        KEY_i[0] = 1'b0;
        cycles(120);
        check("t6_press_cnt", press_cnt[0], p0 + 1);
        check("t6_long_cnt", long_cnt[0] - l0, LONG_EXP);
        long_lat = (long_cnt[0] != l0) ? long_at[0] - c : -1;
        check("t6_long_lat", long_lat, (LONG_EXP != 0) ? 83 : -1);
        KEY_i[0] = 1'b1;
        cycles(60);
        check("t6_no_repeat", long_cnt[0] - l0, LONG_EXP);
        check("t6_k1_long", long_cnt[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
